// File: rtl/elev_call_panel.sv
`default_nettype none
// ============================================================================
//  Module      : elev_call_panel
//  Description : Floor-call request panel for the elevator controller.
//                Synchronises the raw call buttons, latches the pending calls
//                and dispatches them one at a time in SCAN order. Each target
//                is held as a one-hot floorBtn until the car arrives with the
//                door open.
//                Optional feature macro: ELEV_PANEL_LAMP_EN adds the lampOut
//                port, which drives the per-floor call lamps.
//  Revision    : 1.0 - initial release
// ============================================================================
module elev_call_panel #(
    parameter  int NUM_FLOORS   = 4,
    parameter  int DWELL_CYCLES = 2,
    localparam int FLW          = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btnRaw,
    input  logic [FLW-1:0]        floorSel,
    input  logic                  door,
    output logic [NUM_FLOORS-1:0] floorBtn,
    output logic [NUM_FLOORS-1:0] pendReq,
    output logic                  busy,
    output logic                  dir
`ifdef ELEV_PANEL_LAMP_EN
    ,
    output logic [NUM_FLOORS-1:0] lampOut
`endif
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        TRAVEL   = 2'd2,
        DWELL    = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [NUM_FLOORS-1:0]   sync1, sync2, sync3;
    logic [NUM_FLOORS-1:0]   press_edge, here_mask, eff_pend;
    logic [NUM_FLOORS-1:0]   clr_mask, pend_next, btn_next;
    logic [FLW-1:0]          tgt, tgt_next, sel_tgt, up_idx, dn_idx;
    logic                    dir_next, sel_dir, up_found, dn_found, here_pend;
    logic [CW-1:0]           dwell_cnt, dwell_next;

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLW-1:0] f);
        onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLW'(i) == f) onehot[i] = 1'b1;
        end
    endfunction

    // Two-flop synchronizer plus a third stage remembering the previous level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= btnRaw;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // A call at the car's own floor with the door open is already served, so it is masked out
    assign press_edge = sync2 & ~sync3;
    assign here_mask  = door ? onehot(floorSel) : '0;
    assign eff_pend   = pendReq & ~here_mask;
    assign here_pend  = |(eff_pend & onehot(floorSel));
    assign busy       = (state != IDLE);

    // SCAN target choice: nearest call strictly ahead, otherwise reverse and take the nearest behind
    always_comb begin
        up_found = 1'b0;
        up_idx   = '0;
        dn_found = 1'b0;
        dn_idx   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (eff_pend[i] && (FLW'(i) > floorSel)) begin
                up_found = 1'b1;
                up_idx   = FLW'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (eff_pend[i] && (FLW'(i) < floorSel)) begin
                dn_found = 1'b1;
                dn_idx   = FLW'(i);
            end
        end
        sel_dir = dir;
        sel_tgt = floorSel;
        if (dir) begin
            if (up_found) begin
                sel_tgt = up_idx;
            end else begin
                sel_dir = 1'b0;
                if (!here_pend) sel_tgt = dn_idx;
            end
        end else begin
            if (dn_found) begin
                sel_tgt = dn_idx;
            end else begin
                sel_dir = 1'b1;
                if (!here_pend) sel_tgt = up_idx;
            end
        end
    end

    // Next-state logic: dispatch, wait for door close, wait for arrival, then dwell
    always_comb begin
        state_next = state;
        btn_next   = floorBtn;
        tgt_next   = tgt;
        dir_next   = dir;
        dwell_next = dwell_cnt;
        clr_mask   = '0;
        case (state)
            IDLE: begin
                btn_next = '0;
                clr_mask = here_mask;
                if (eff_pend != '0) begin
                    state_next = DISPATCH;
                    tgt_next   = sel_tgt;
                    dir_next   = sel_dir;
                    btn_next   = onehot(sel_tgt);
                end
            end
            DISPATCH: begin
                if (!door) state_next = TRAVEL;
            end
            TRAVEL: begin
                if (door && (floorSel == tgt)) begin
                    clr_mask   = onehot(tgt);
                    btn_next   = '0;
                    dwell_next = '0;
                    state_next = DWELL;
                end
            end
            DWELL: begin
                if (dwell_cnt == CW'(DWELL_CYCLES - 1)) begin
                    dwell_next = '0;
                    state_next = IDLE;
                end else begin
                    dwell_next = dwell_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                btn_next   = '0;
            end
        endcase
        // a press for a floor being cleared on this edge is dropped with it
        pend_next = (pendReq | press_edge) & ~clr_mask;
    end

    // State, target, direction and pending-call registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            floorBtn  <= '0;
            pendReq   <= '0;
            tgt       <= '0;
            dir       <= 1'b1;
            dwell_cnt <= '0;
        end else begin
            state     <= state_next;
            floorBtn  <= btn_next;
            pendReq   <= pend_next;
            tgt       <= tgt_next;
            dir       <= dir_next;
            dwell_cnt <= dwell_next;
        end
    end

`ifdef ELEV_PANEL_LAMP_EN
    // Call lamps show every pending call plus the floor currently being served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lampOut <= '0;
        end else begin
            lampOut <= pendReq | (busy ? onehot(tgt) : '0);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_elev_call_panel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elev_call_panel
//  Description : Self-checking bench for elev_call_panel with a behavioural
//                reference model and a one-floor-per-cycle controller model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elev_call_panel;
    localparam int N  = 4;
    localparam int DW = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btnRaw;
    logic [1:0]   floorSel;
    logic         door;
    logic [N-1:0] floorBtn;
    logic [N-1:0] pendReq;
    logic         busy;
    logic         dir;
`ifdef ELEV_PANEL_LAMP_EN
    logic [N-1:0] lampOut;
`endif

    int n_vec = 0;
    int n_err = 0;

    // reference model
    bit [N-1:0] m_hist [3];
    bit [N-1:0] m_pend;
    bit [N-1:0] m_lamp;
    int         m_tgt;
    int         m_last;
    bit         m_closed;
    int         m_dwell;
    bit         m_dir;
    // controller model
    int         car;
    bit         cdoor;
    // dispatch log
    logic [N-1:0] prev_btn;
    logic [N-1:0] disp_q [$];

    always #5 clk = ~clk;

    elev_call_panel #(.NUM_FLOORS(N), .DWELL_CYCLES(DW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .btnRaw   (btnRaw),
        .floorSel (floorSel),
        .door     (door),
        .floorBtn (floorBtn),
        .pendReq  (pendReq),
        .busy     (busy),
        .dir      (dir)
`ifdef ELEV_PANEL_LAMP_EN
        ,
        .lampOut  (lampOut)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (m_tgt >= 0) || (m_dwell > 0);
    endfunction

    function automatic logic [N-1:0] m_btn();
        logic [N-1:0] one;
        one = 1;
        return (m_tgt >= 0) ? (one << m_tgt) : '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_pend   = '0;
        m_lamp   = '0;
        m_tgt    = -1;
        m_last   = 0;
        m_closed = 1'b0;
        m_dwell  = 0;
        m_dir    = 1'b1;
        car      = 0;
        cdoor    = 1'b1;
        prev_btn = '0;
    endtask

    // walk outward from the car floor; reverse once if nothing lies ahead
    task automatic pick(input bit [N-1:0] eff, input int fs, input bit din,
                        output int t, output bit dout);
        int f;
        t    = -1;
        dout = din;
        for (int k = 1; k < N; k++) begin
            f = din ? fs + k : fs - k;
            if (t < 0 && f >= 0 && f < N && eff[f]) t = f;
        end
        if (t < 0) begin
            dout = !din;
            for (int k = 0; k < N; k++) begin
                f = dout ? fs + k : fs - k;
                if (t < 0 && f >= 0 && f < N && eff[f]) t = f;
            end
        end
    endtask

    task automatic model_step(input bit [N-1:0] raw, input int fs, input bit dr);
        bit [N-1:0] edges, clr, eff, one;
        int t;
        bit nd;
        one    = 1;
        edges  = m_hist[1] & ~m_hist[2];
        clr    = '0;
        m_lamp = m_pend | (m_busy() ? (one << m_last) : '0);
        if (m_tgt < 0 && m_dwell == 0) begin
            if (dr) clr = one << fs;
            eff = m_pend & ~clr;
            if (eff != '0) begin
                pick(eff, fs, m_dir, t, nd);
                m_tgt    = t;
                m_last   = t;
                m_dir    = nd;
                m_closed = 1'b0;
            end
        end else if (m_tgt >= 0) begin
            if (!m_closed) begin
                if (!dr) m_closed = 1'b1;
            end else if (dr && fs == m_tgt) begin
                clr     = one << m_tgt;
                m_tgt   = -1;
                m_dwell = DW;
            end
        end else begin
            m_dwell--;
        end
        m_pend    = (m_pend | edges) & ~clr;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = raw;
    endtask

    task automatic ctl_drive(input bit wander);
        if (m_tgt >= 0) begin
            if (cdoor)             cdoor = 1'b0;
            else if (car < m_tgt)  car++;
            else if (car > m_tgt)  car--;
            else                   cdoor = 1'b1;
        end else if (wander && $urandom_range(0, 7) == 0) begin
            cdoor = !cdoor;
        end
    endtask

    // called at a falling edge: compare, drive next inputs, advance the model
    task automatic step(input bit [N-1:0] raw, input bit wander);
        check_val("floorBtn", floorBtn, m_btn());
        check_val("pendReq", pendReq, m_pend);
        check_val("busy", busy, m_busy());
        check_val("dir", dir, m_dir);
`ifdef ELEV_PANEL_LAMP_EN
        check_val("lampOut", lampOut, m_lamp);
`endif
        if (prev_btn == '0 && floorBtn != '0) disp_q.push_back(floorBtn);
        prev_btn = floorBtn;
        ctl_drive(wander);
        btnRaw   = raw;
        floorSel = 2'(car);
        door     = cdoor;
        model_step(raw, car, cdoor);
        @(negedge clk);
    endtask

    task automatic run_idle(input bit [N-1:0] raw_first);
        bit done;
        done = 1'b0;
        step(raw_first, 1'b0);
        for (int i = 0; i < 80 && !done; i++) begin
            if (!m_busy() && m_pend == '0 && m_hist[0] == '0 && m_hist[1] == '0 && m_hist[2] == '0)
                done = 1'b1;
            else
                step('0, 1'b0);
        end
        check_val("drain_timeout", done, 1);
    endtask

    task automatic wait_travel();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_tgt >= 0 && m_closed) ok = 1'b1;
            else step('0, 1'b0);
        end
        check_val("travel_timeout", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [N-1:0] rr;
        model_reset();
        rst = 1'b1; btnRaw = '0; floorSel = '0; door = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_floorBtn", floorBtn, 0);
        check_val("rst_pendReq", pendReq, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_dir", dir, 1);
        @(negedge clk);
        rst = 1'b0;

        // single call to floor 2
        step(4'b0100, 1'b0);
        step('0, 1'b0);
        step('0, 1'b0);
        check_val("single_pend", pendReq, 4'b0100);
        check_val("single_btn_early", floorBtn, 4'b0000);
        run_idle('0);
        check_val("single_done_pend", pendReq, 0);
        check_val("single_done_btn", floorBtn, 0);
        check_val("single_done_busy", busy, 0);

        // back to floor 0, then SCAN order from there
        run_idle(4'b0001);
        disp_q.delete();
        run_idle(4'b1010);
        check_val("scan_count", disp_q.size(), 2);
        check_val("scan_first", (disp_q.size() > 0) ? disp_q[0] : '0, 4'b0010);
        check_val("scan_second", (disp_q.size() > 1) ? disp_q[1] : '0, 4'b1000);

        // get to floor 1 heading up, then reversal
        run_idle(4'b0001);
        run_idle(4'b0010);
        check_val("rev_pre_dir", dir, 1);
        disp_q.delete();
        run_idle(4'b1001);
        check_val("rev_first", (disp_q.size() > 0) ? disp_q[0] : '0, 4'b1000);
        check_val("rev_second", (disp_q.size() > 1) ? disp_q[1] : '0, 4'b0001);
        check_val("rev_dir", dir, 0);

        // no retarget while travelling
        disp_q.delete();
        step(4'b1000, 1'b0);
        wait_travel();
        run_idle(4'b0100);
        check_val("noretgt_first", (disp_q.size() > 0) ? disp_q[0] : '0, 4'b1000);
        check_val("noretgt_second", (disp_q.size() > 1) ? disp_q[1] : '0, 4'b0100);

        // a call at the car's own floor with the door open is never dispatched
        run_idle(4'b0010);
        disp_q.delete();
        run_idle(4'b0010);
        check_val("here_nodisp", disp_q.size(), 0);
        check_val("here_btn", floorBtn, 0);

        // asynchronous reset in the middle of a trip
        step(4'b1000, 1'b0);
        wait_travel();
        step('0, 1'b0);
        check_val("pre_rst_pend", pendReq, 4'b1000);
        #2 rst = 1'b1;
        btnRaw = '0;
        #1;
        check_val("async_floorBtn", floorBtn, 0);
        check_val("async_pendReq", pendReq, 0);
        check_val("async_busy", busy, 0);
        check_val("async_dir", dir, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        floorSel = '0; door = 1'b1;

        // randomized button activity with a wandering idle door
        rr = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
            step(rr, 1'b1);
        end
        run_idle('0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
